// File: rtl/sh7604_ibus_master_pkg.sv
// Shared SH7604 IBUS definitions: access sizes, master FSM states and
// the big-endian byte-lane helpers used by the IBUS initiator.
package sh7604_ibus_master_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    WORD = 2'd1,
    LONG = 2'd2
  } IBUS_SIZE_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } IBUS_STATE_t;

  // Byte-lane enables; BA[3] selects bits 31:24 (lowest byte address).
  function automatic logic [3:0] BA_DECODE(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] ba;
    ba = 4'b0000;
    case (IBUS_SIZE_t'(size))
      BYTE: begin
        case (a)
          2'd0:    ba = 4'b1000;
          2'd1:    ba = 4'b0100;
          2'd2:    ba = 4'b0010;
          default: ba = 4'b0001;
        endcase
      end
      WORD:    ba = a[1] ? 4'b0011 : 4'b1100;
      LONG:    ba = 4'b1111;
      default: ba = 4'b0000;
    endcase
    return ba;
  endfunction

  // Replicate right-justified write data onto every lane it could occupy.
  function automatic logic [31:0] WDATA_REPL(input logic [1:0] size, input logic [31:0] di);
    logic [31:0] wd;
    case (IBUS_SIZE_t'(size))
      BYTE:    wd = {4{di[7:0]}};
      WORD:    wd = {2{di[15:0]}};
      default: wd = di;
    endcase
    return wd;
  endfunction

  // Pull the addressed lane down to the LSBs and zero the rest.
  function automatic logic [31:0] RDATA_EXTRACT(input logic [1:0] size, input logic [1:0] a,
                                                input logic [31:0] di);
    logic [31:0] rd;
    case (IBUS_SIZE_t'(size))
      BYTE: begin
        case (a)
          2'd0:    rd = {24'h000000, di[31:24]};
          2'd1:    rd = {24'h000000, di[23:16]};
          2'd2:    rd = {24'h000000, di[15:8]};
          default: rd = {24'h000000, di[7:0]};
        endcase
      end
      WORD:    rd = a[1] ? {16'h0000, di[15:0]} : {16'h0000, di[31:16]};
      default: rd = di;
    endcase
    return rd;
  endfunction

  // Misaligned word/long or the reserved size never reaches the bus.
  function automatic logic ADDR_ERROR(input logic [1:0] size, input logic [1:0] a);
    logic err;
    case (IBUS_SIZE_t'(size))
      BYTE:    err = 1'b0;
      WORD:    err = a[0];
      LONG:    err = (a != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/sh7604_ibus_master.sv
// SH7604 IBUS initiator: turns one core/DMAC data access into a peripheral
// bus cycle, waits out BUSY (with a timeout) and returns aligned read data.
module sh7604_ibus_master
  import sh7604_ibus_master_pkg::*;
#(
  parameter int TMO_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ce_r_i,
  input  logic        ce_f_i,
  input  logic        en_i,
  input  logic        res_n_i,
  input  logic [31:0] m_a_i,
  input  logic [31:0] m_di_i,
  input  logic [1:0]  m_size_i,
  input  logic        m_we_i,
  input  logic        m_req_i,
  output logic [31:0] m_do_o,
  output logic        m_ack_o,
  output logic        m_berr_o,
  output logic [31:0] ibus_a_o,
  output logic [31:0] ibus_do_o,
  output logic [3:0]  ibus_ba_o,
  output logic        ibus_we_o,
  output logic        ibus_req_o,
  input  logic [31:0] ibus_di_i,
  input  logic        ibus_busy_i,
  input  logic        ibus_act_i
);

  localparam int CNT_W = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TMO_CYCLES);

  IBUS_STATE_t      state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      di_q, di_d;
  logic [1:0]       size_q, size_d;
  logic             we_q, we_d;
  logic             berr_q, berr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             bus_active;

  // Slaves launch BUSY/ACT on the falling phase; this side only samples on CE_R.
  logic unused_ce_f;
  assign unused_ce_f = ce_f_i;

  // Next-state logic: accept, issue, wait out BUSY, then complete for one period.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    di_d    = di_q;
    size_d  = size_q;
    we_d    = we_q;
    berr_d  = berr_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        berr_d = 1'b0;
        cnt_d  = '0;
        if (m_req_i && !m_ack_o) begin
          a_d     = m_a_i;
          di_d    = m_di_i;
          size_d  = m_size_i;
          we_d    = m_we_i;
          rdata_d = '0;
          if (ADDR_ERROR(m_size_i, m_a_i[1:0])) begin
            berr_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end

      REQ: begin
        if (!ibus_act_i) begin
          berr_d  = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else if (ibus_busy_i) begin
          cnt_d   = CNT_W'(1);
          state_d = WAIT;
        end else begin
          rdata_d = we_q ? 32'h0 : RDATA_EXTRACT(size_q, a_q[1:0], ibus_di_i);
          state_d = DONE;
        end
      end

      WAIT: begin
        if (!ibus_busy_i) begin
          rdata_d = we_q ? 32'h0 : RDATA_EXTRACT(size_q, a_q[1:0], ibus_di_i);
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_LIMIT) begin
            berr_d  = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers: hard reset, soft reset on CE_R, otherwise advance on CE_R && EN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      di_q    <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      berr_q  <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else if (ce_r_i && !res_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      di_q    <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      berr_q  <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else if (ce_r_i && en_i) begin
      state_q <= state_d;
      a_q     <= a_d;
      di_q    <= di_d;
      size_q  <= size_d;
      we_q    <= we_d;
      berr_q  <= berr_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_active = (state_q == REQ) || (state_q == WAIT);

  assign ibus_req_o = bus_active;
  assign ibus_we_o  = bus_active & we_q;
  assign ibus_a_o   = bus_active ? a_q : 32'h0;
  assign ibus_ba_o  = bus_active ? BA_DECODE(size_q, a_q[1:0]) : 4'b0000;
  assign ibus_do_o  = (bus_active && we_q) ? WDATA_REPL(size_q, di_q) : 32'h0;

  assign m_ack_o  = (state_q == DONE);
  assign m_berr_o = m_ack_o & berr_q;
  assign m_do_o   = rdata_q;

endmodule

// File: tb/tb_sh7604_ibus_master.sv
// Self-checking bench for the SH7604 IBUS initiator: directed scenarios plus
// random accesses checked against an arithmetic model of the bus rules.
module tb_sh7604_ibus_master;

  localparam int TMO = 255;

  logic        clk;
  logic        rstN;
  logic        ceR;
  logic        ceF;
  logic        enI;
  logic        resN;
  logic [31:0] mA;
  logic [31:0] mDi;
  logic [1:0]  mSize;
  logic        mWe;
  logic        mReq;
  logic [31:0] mDo;
  logic        mAck;
  logic        mBerr;
  logic [31:0] ibusA;
  logic [31:0] ibusDo;
  logic [3:0]  ibusBa;
  logic        ibusWe;
  logic        ibusReq;
  logic [31:0] ibusDi;
  logic        ibusBusy;
  logic        ibusAct;

  int nAssert = 0;
  int nFail   = 0;

  sh7604_ibus_master #(.TMO_CYCLES(TMO)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .ce_r_i      (ceR),
    .ce_f_i      (ceF),
    .en_i        (enI),
    .res_n_i     (resN),
    .m_a_i       (mA),
    .m_di_i      (mDi),
    .m_size_i    (mSize),
    .m_we_i      (mWe),
    .m_req_i     (mReq),
    .m_do_o      (mDo),
    .m_ack_o     (mAck),
    .m_berr_o    (mBerr),
    .ibus_a_o    (ibusA),
    .ibus_do_o   (ibusDo),
    .ibus_ba_o   (ibusBa),
    .ibus_we_o   (ibusWe),
    .ibus_req_o  (ibusReq),
    .ibus_di_i   (ibusDi),
    .ibus_busy_i (ibusBusy),
    .ibus_act_i  (ibusAct)
  );

  // Clock and alternating rising/falling clock-enable phases.
  initial begin
    clk = 1'b0;
    ceR = 1'b0;
    ceF = 1'b1;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    ceR = ~ceR;
    ceF = ~ceF;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion");
    $fatal(1);
  end

  // Model: expected byte lanes from size and address.
  function automatic logic [3:0] expBa(input logic [1:0] size, input logic [1:0] a);
    if (size == 2'd0) return 4'b1000 >> a;
    if (size == 2'd1) return 4'b1100 >> (2 * a[1]);
    if (size == 2'd2) return 4'b1111;
    return 4'b0000;
  endfunction

  // Model: lane-replicated write data via multiplication.
  function automatic logic [31:0] expRepl(input logic [1:0] size, input logic [31:0] di);
    if (size == 2'd0) return {24'h0, di[7:0]} * 32'h01010101;
    if (size == 2'd1) return {16'h0, di[15:0]} * 32'h00010001;
    return di;
  endfunction

  // Model: right-justified read data via shift and mask.
  function automatic logic [31:0] expExtract(input logic [1:0] size, input logic [1:0] a,
                                             input logic [31:0] rd);
    int sh;
    if (size == 2'd0) begin
      sh = 8 * (3 - int'(a));
      return (rd >> sh) & 32'h000000FF;
    end
    if (size == 2'd1) begin
      sh = a[1] ? 0 : 16;
      return (rd >> sh) & 32'h0000FFFF;
    end
    return rd;
  endfunction

  function automatic logic expAddrErr(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a != 2'b00);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next CE_R clock edge.
  task automatic stepR();
    do @(posedge clk); while (!ceR);
    #1;
  endtask

  // One complete access: drive the request, play the slave, check the outcome.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] di,
                               input logic [1:0] size, input logic we, input logic act,
                               input int busyN, input logic [31:0] rd);
    int   e;
    int   reqCnt;
    int   expLat;
    logic expErr;
    logic addrErr;
    addrErr = expAddrErr(size, a[1:0]);
    if (addrErr) begin
      expLat = 0; expErr = 1'b1;
    end else if (!act) begin
      expLat = 1; expErr = 1'b1;
    end else if (busyN >= TMO) begin
      expLat = TMO; expErr = 1'b1;
    end else begin
      expLat = 1 + busyN; expErr = 1'b0;
    end

    mA = a; mDi = di; mSize = size; mWe = we; mReq = 1'b1;
    ibusAct = act; ibusBusy = (busyN > 0); ibusDi = rd;
    stepR();
    e = 0;
    reqCnt = 0;
    if (addrErr) checkOutput({tag, "/noBusReq"}, {31'b0, ibusReq}, 32'h0);
    while (!mAck && e < TMO + 20) begin
      if (e == 0 && !addrErr) begin
        checkOutput({tag, "/ibusReq"}, {31'b0, ibusReq}, 32'h1);
        checkOutput({tag, "/ibusA"}, ibusA, a);
        checkOutput({tag, "/ibusBa"}, {28'b0, ibusBa}, {28'b0, expBa(size, a[1:0])});
        checkOutput({tag, "/ibusWe"}, {31'b0, ibusWe}, {31'b0, we});
        checkOutput({tag, "/ibusDo"}, ibusDo, we ? expRepl(size, di) : 32'h0);
      end
      reqCnt += int'(ibusReq);
      ibusBusy = (e < busyN);
      stepR();
      e++;
    end
    checkOutput({tag, "/ack"}, {31'b0, mAck}, 32'h1);
    checkOutput({tag, "/latency"}, 32'(e), 32'(expLat));
    checkOutput({tag, "/reqCycles"}, 32'(reqCnt), 32'(expLat));
    checkOutput({tag, "/berr"}, {31'b0, mBerr}, {31'b0, expErr});
    if (expErr || !we)
      checkOutput({tag, "/mDo"}, mDo, expErr ? 32'h0 : expExtract(size, a[1:0], rd));
    mReq = 1'b0; ibusBusy = 1'b0; ibusAct = 1'b0;
    stepR();
    checkOutput({tag, "/ackPulse"}, {31'b0, mAck}, 32'h0);
  endtask

  // Directed steps followed by randomized accesses.
  initial begin
    rstN = 1'b0; enI = 1'b1; resN = 1'b1;
    mA = '0; mDi = '0; mSize = '0; mWe = 1'b0; mReq = 1'b0;
    ibusDi = '0; ibusBusy = 1'b0; ibusAct = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst/mDo", mDo, 32'h0);
    checkOutput("rst/mAck", {31'b0, mAck}, 32'h0);
    checkOutput("rst/mBerr", {31'b0, mBerr}, 32'h0);
    checkOutput("rst/ibusA", ibusA, 32'h0);
    checkOutput("rst/ibusDo", ibusDo, 32'h0);
    checkOutput("rst/ibusBa", {28'b0, ibusBa}, 32'h0);
    checkOutput("rst/ibusWe", {31'b0, ibusWe}, 32'h0);
    checkOutput("rst/ibusReq", {31'b0, ibusReq}, 32'h0);
    rstN = 1'b1;
    stepR();
    $display("[TB] reset released, directed accesses");

    applyStimulus("longRd", 32'hFFFFFF1C, 32'h0, 2'd2, 1'b0, 1'b1, 0, 32'h12345678);
    applyStimulus("byteWr", 32'hFFFFFE11, 32'h000000A5, 2'd0, 1'b1, 1'b1, 0, 32'h0);
    applyStimulus("wordRdBusy", 32'hFFFFFF06, 32'h0, 2'd1, 1'b0, 1'b1, 3, 32'hDEADBEEF);
    applyStimulus("longWrMis", 32'hFFFFFF02, 32'h11223344, 2'd2, 1'b1, 1'b1, 0, 32'h0);
    applyStimulus("wordMis", 32'hFFFFFF05, 32'h0, 2'd1, 1'b0, 1'b1, 0, 32'h0);
    applyStimulus("rsvdSize", 32'hFFFFFF00, 32'h0, 2'd3, 1'b0, 1'b1, 0, 32'h0);
    applyStimulus("unmapped", 32'hFFFFFC00, 32'h0, 2'd2, 1'b0, 1'b0, 0, 32'hFFFFFFFF);
    applyStimulus("busy254", 32'hFFFFFF12, 32'h0, 2'd1, 1'b0, 1'b1, 254, 32'hA1B2C3D4);
    applyStimulus("timeout", 32'hFFFFFF10, 32'h0, 2'd2, 1'b0, 1'b1, 300, 32'h55555555);

    // Soft reset in the middle of a waited access.
    mA = 32'hFFFFFF04; mSize = 2'd2; mWe = 1'b0; mReq = 1'b1;
    ibusAct = 1'b1; ibusBusy = 1'b1; ibusDi = 32'h0BADF00D;
    stepR();
    stepR();
    stepR();
    checkOutput("resN/reqBefore", {31'b0, ibusReq}, 32'h1);
    resN = 1'b0;
    stepR();
    checkOutput("resN/reqDropped", {31'b0, ibusReq}, 32'h0);
    checkOutput("resN/noAck", {31'b0, mAck}, 32'h0);
    resN = 1'b1; mReq = 1'b0; ibusBusy = 1'b0; ibusAct = 1'b0;
    stepR();
    checkOutput("resN/stillNoAck", {31'b0, mAck}, 32'h0);
    applyStimulus("afterResN", 32'hFFFFFF23, 32'h0, 2'd0, 1'b0, 1'b1, 1, 32'h01020304);

    // EN low freezes an access in progress.
    mA = 32'hFFFFFF08; mSize = 2'd2; mWe = 1'b0; mReq = 1'b1;
    ibusAct = 1'b1; ibusBusy = 1'b0; ibusDi = 32'hCAFEF00D;
    stepR();
    enI = 1'b0;
    repeat (3) stepR();
    checkOutput("en/reqHeld", {31'b0, ibusReq}, 32'h1);
    checkOutput("en/noAck", {31'b0, mAck}, 32'h0);
    enI = 1'b1;
    stepR();
    checkOutput("en/ack", {31'b0, mAck}, 32'h1);
    checkOutput("en/mDo", mDo, 32'hCAFEF00D);
    mReq = 1'b0; ibusAct = 1'b0;
    stepR();
    checkOutput("en/ackPulse", {31'b0, mAck}, 32'h0);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rdi;
      logic [31:0] rrd;
      logic [1:0]  rsz;
      logic        rwe;
      logic        ract;
      int          rbusy;
      ra    = $urandom;
      rdi   = $urandom;
      rrd   = $urandom;
      rsz   = 2'($urandom_range(0, 3));
      rwe   = 1'($urandom_range(0, 1));
      ract  = ($urandom_range(0, 5) != 0);
      rbusy = ract ? int'($urandom_range(0, 4)) : 0;
      applyStimulus($sformatf("rnd%0d", i), ra, rdi, rsz, rwe, ract, rbusy, rrd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
